// File: rtl/pcie_tx_arbiter.sv
// Round-robin TLP arbiter: zero-cycle grant in IDLE, requester locked until EOP,
// single registered output stage with skid-free load = ~out_valid | out_ready.
`timescale 1ns/1ps
module pcie_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 512
) (
  input  logic                       avl_clk,
  input  logic                       avl_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_sop,
  input  logic [NUM_REQ-1:0]         req_eop,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_enable,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] cur_grant,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     winner, cand, sel;
  logic              found, load, xfer, proto_d;
  logic [NUM_REQ-1:0] eligible;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : GW'(32'(idx) + 32'd1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign eligible  = req_valid & req_sop & req_enable;
  assign load      = ~out_valid | out_ready;
  assign busy      = (state_q == LOCKED);
  assign cur_grant = grant_q;

  // First eligible requester searching upward from ptr, wrapping.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = GW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    proto_d   = 1'b0;
    req_ready = '0;
    sel       = (state_q == LOCKED) ? grant_q : winner;
    if (load && (state_q == LOCKED || found)) req_ready[sel] = 1'b1;
    xfer = req_valid[sel] & req_ready[sel];
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (req_eop[sel]) begin
            ptr_d = next_idx(sel);
          end else begin
            state_d = LOCKED;
            grant_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          proto_d = req_sop[sel];
          if (req_eop[sel]) begin
            state_d = IDLE;
            ptr_d   = next_idx(sel);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge avl_clk) begin
    if (!avl_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      proto_err <= proto_d;
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_sop <= req_sop[sel];
          out_eop <= req_eop[sel];
        end
      end
    end
  end

  // Payload needs no reset; it is qualified by out_valid.
  always_ff @(posedge avl_clk) begin
    if (load && xfer) out_data <= data_arr[sel];
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomized bench for pcie_tx_arbiter: transaction-level arbitration model,
// expected beats queued at acceptance and checked by an output monitor.
`timescale 1ns/1ps
module tb_pcie_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 512;
  localparam int unsigned GW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic            avl_clk = 1'b0;
  logic            avl_rst_n;
  logic [N-1:0]    req_valid, req_sop, req_eop, req_enable, req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_sop, out_eop, out_ready, busy, proto_err;
  logic [DW-1:0]   out_data;
  logic [GW-1:0]   cur_grant;

  pcie_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .avl_clk    (avl_clk),
    .avl_rst_n  (avl_rst_n),
    .req_valid  (req_valid),
    .req_sop    (req_sop),
    .req_eop    (req_eop),
    .req_data   (req_data),
    .req_enable (req_enable),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .cur_grant  (cur_grant),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  always #5 avl_clk = ~avl_clk;

  int    checks = 0;
  int    passes = 0;
  beat_t sb[$];

  // Reference model: owning requester (-1 = none), round-robin pointer,
  // expected output-register occupancy and protocol-error pulse.
  int owner;
  int ptr;
  bit m_ov;
  bit m_proto;

  // Per-requester packet sources.
  bit    have [N];
  beat_t cur  [N];
  int    rem  [N];

  int unsigned p_start, p_valid, p_ready, p_en, p_viol, p_rst, max_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got sop=%0b eop=%0b data=%h, expected sop=%0b eop=%0b data=%h",
                  name, act.sop, act.eop, act.data, exp.sop, exp.eop, exp.data);
  endtask

  function automatic beat_t make_beat(input int i, input bit first, input bit last, input bit viol);
    beat_t b;
    for (int w = 0; w < int'(DW / 32); w++) b.data[w*32 +: 32] = $urandom;
    b.data[DW-1 -: 8] = 8'(i);
    b.sop = first | viol;
    b.eop = last;
    return b;
  endfunction

  task automatic model_reset();
    owner   = -1;
    ptr     = 0;
    m_ov    = 1'b0;
    m_proto = 1'b0;
    sb.delete();
    for (int i = 0; i < int'(N); i++) have[i] = 1'b0;
  endtask

  // One clock: check registered outputs, drive new inputs, predict the edge.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit load, xfer;
    int wi, c;
    @(negedge avl_clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("proto_err", 32'(proto_err), 32'(m_proto));
    if (owner >= 0) chk("cur_grant", 32'(cur_grant), 32'(owner));

    avl_rst_n = ($urandom_range(999) >= p_rst);
    out_ready = ($urandom_range(99) < p_ready);
    for (int i = 0; i < int'(N); i++) begin
      if (!have[i] && $urandom_range(99) < p_start) begin
        rem[i]  = int'($urandom_range(max_len, 1));
        cur[i]  = make_beat(i, 1'b1, rem[i] == 1, 1'b0);
        have[i] = 1'b1;
      end
      req_valid[i]            = have[i] && ($urandom_range(99) < p_valid);
      req_sop[i]              = cur[i].sop;
      req_eop[i]              = cur[i].eop;
      req_data[i*DW +: DW]    = cur[i].data;
      req_enable[i]           = ($urandom_range(99) < p_en);
    end
    #1;
    if (!avl_rst_n) begin
      model_reset();
      return;
    end

    load    = !m_ov || out_ready;
    exp_rdy = '0;
    wi      = -1;
    if (load) begin
      if (owner >= 0) wi = owner;
      else begin
        for (int k = 0; k < int'(N); k++) begin
          c = (ptr + k) % int'(N);
          if (wi < 0 && req_valid[c] && req_sop[c] && req_enable[c]) wi = c;
        end
      end
    end
    if (wi >= 0) exp_rdy[wi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));

    xfer    = (wi >= 0) && req_valid[wi];
    m_proto = 1'b0;
    if (load) m_ov = xfer;
    if (xfer) begin
      sb.push_back(cur[wi]);
      if (owner >= 0) begin
        m_proto = cur[wi].sop;
        if (cur[wi].eop) begin
          ptr   = (owner + 1) % int'(N);
          owner = -1;
        end
      end else if (cur[wi].eop) begin
        ptr = (wi + 1) % int'(N);
      end else begin
        owner = wi;
      end
      rem[wi]--;
      if (rem[wi] > 0) cur[wi] = make_beat(wi, 1'b0, rem[wi] == 1, $urandom_range(99) < p_viol);
      else have[wi] = 1'b0;
    end
  endtask

  task automatic run_phase(input int unsigned st, input int unsigned va, input int unsigned rd,
                           input int unsigned en, input int unsigned vi, input int unsigned rs,
                           input int unsigned ml, input int cycles);
    p_start = st; p_valid = va; p_ready = rd; p_en = en;
    p_viol  = vi; p_rst   = rs; max_len = ml;
    repeat (cycles) cycle();
  endtask

  // Output monitor: pops the expected beat on every downstream handshake and
  // checks that a stalled beat is held unchanged.
  initial begin : monitor
    beat_t act, exp, held;
    bit    stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge avl_clk);
      #2;
      if (avl_rst_n !== 1'b1) begin
        stalled = 1'b0;
        continue;
      end
      act.data = out_data;
      act.sop  = out_sop;
      act.eop  = out_eop;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk_beat("stall_hold", act, held);
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL beat_unexpected: got data=%h, expected no beat", out_data);
        end else begin
          exp = sb.pop_front();
          chk_beat("out_beat", act, exp);
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = act;
      end
    end
  end

  initial begin
    avl_rst_n  = 1'b0;
    req_valid  = '0;
    req_sop    = '0;
    req_eop    = '0;
    req_data   = '0;
    req_enable = '0;
    out_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge avl_clk);

    //        start valid ready en  viol rst  len cycles
    run_phase(100,  100,  100, 100, 0,   0,   1,  40);   // single-beat round robin
    run_phase(60,   100,  100, 100, 0,   0,   4,  300);  // multi-beat, full rate
    run_phase(60,   80,   30,  100, 0,   0,   4,  400);  // downstream stalls
    run_phase(60,   80,   70,  50,  0,   0,   4,  400);  // enable mask toggling
    run_phase(60,   80,   70,  90,  25,  0,   4,  400);  // mid-packet sop errors
    run_phase(60,   80,   70,  90,  10,  20,  4,  1000); // random resets
    run_phase(0,    100,  100, 100, 0,   0,   4,  40);   // drain

    @(negedge avl_clk);
    #5;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 4, as the number of TLP requesters (2..8).
REQ-002 The block SHALL take parameter DATA_W, default 512, as the beat data width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: avl_clk  input  1  sole clock, all logic on rising edge.
REQ-004 avl_rst_n  input  1  synchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 req_sop  input  NUM_REQ  per-requester start of TLP.
REQ-007 req_eop  input  NUM_REQ  per-requester end of TLP.
REQ-008 req_data  input  NUM_REQ x DATA_W  per-requester beat data.
REQ-009 req_enable  input  NUM_REQ  per-requester arbitration enable mask.
REQ-010 req_ready  output  NUM_REQ  per-requester beat accept, at most one bit high; combinational.
REQ-011 out_valid  output  1  registered output beat valid.
REQ-012 out_sop / out_eop  output  1 each  registered SOP/EOP of the output beat.
REQ-013 out_data  output  DATA_W  registered output beat data.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 cur_grant  output  clog2(NUM_REQ)  index of the owning requester; valid while busy=1.
REQ-016 busy  output  1  high in LOCKED state.
REQ-017 proto_err  output  1  one-cycle pulse on protocol violation.

Function
REQ-018 load SHALL equal ~out_valid | out_ready; output registers SHALL update only when load=1.
REQ-019 A beat SHALL transfer from requester i when req_valid[i] & req_ready[i]; on transfer the output registers SHALL capture that requester's data/sop/eop and set out_valid=1.
REQ-020 When load=1 and no beat transfers, out_valid SHALL become 0.
REQ-021 The FSM SHALL have states IDLE and LOCKED.
REQ-022 In IDLE, requester i SHALL be eligible when req_valid[i] & req_sop[i] & req_enable[i].
REQ-023 In IDLE, the winner SHALL be the first eligible index searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-024 In IDLE with load=1 and a winner, req_ready[winner] SHALL be 1 in the same cycle (zero-cycle arbitration).
REQ-025 IDLE winner beat with eop=1 (single-beat TLP): state SHALL stay IDLE and ptr SHALL become (winner+1) mod NUM_REQ.
REQ-026 IDLE winner beat with eop=0: state SHALL go LOCKED and cur_grant SHALL latch winner.
REQ-027 In LOCKED, req_ready[cur_grant] SHALL equal load, all other req_ready bits SHALL be 0.
REQ-028 In LOCKED, a transferred beat with eop=1 SHALL return state to IDLE and set ptr to (cur_grant+1) mod NUM_REQ.
REQ-029 Deasserting req_enable[cur_grant] while LOCKED SHALL NOT abort the packet; it only blocks the next arbitration.
REQ-030 In IDLE, req_valid=1 with req_sop=0 SHALL be ineligible; such a requester SHALL never receive req_ready in IDLE.
REQ-031 In LOCKED, a transferred beat with req_sop=1 SHALL pulse proto_err for one cycle; the beat SHALL still be forwarded unchanged.
REQ-032 Back-to-back TLPs SHALL sustain one beat per cycle when out_ready=1, including IDLE-to-IDLE single-beat grants.

Reset
REQ-033 With avl_rst_n=0 at a clock edge: state=IDLE, ptr=0, cur_grant=0, busy=0, out_valid=0, out_sop=0, out_eop=0, proto_err=0; out_data SHALL be don't-care.
REQ-034 Reset asserted mid-packet SHALL discard the packet with no further beats; after release arbitration SHALL restart from ptr=0.

Verification
REQ-035 All four requesters hold single-beat TLPs, out_ready=1 -> out grants 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-036 Req 1 sends 3-beat TLP while req 2 is valid with sop -> beats 1a,1b,1c contiguous, busy=1 for beats 1a-1b, then req 2 granted next cycle.
REQ-037 out_ready=0 for 5 cycles during LOCKED -> out_valid stays 1, out_data stable, req_ready all 0, no beat lost or duplicated.
REQ-038 req_enable[0]=0 with req 0 valid, req 3 valid -> only req 3 granted; clearing req_enable[3] mid-packet still completes req 3's TLP.
REQ-039 Granted requester presents sop=1 on its second beat -> proto_err=1 for exactly one cycle, beat forwarded, state remains LOCKED.
REQ-040 Reset pulsed during beat 2 of a 4-beat TLP -> out_valid=0 next cycle, busy=0, next grant taken by lowest-index eligible requester.
